// File: rtl/dca_row_collector_pkg.sv
// dca_row_collector_pkg: shared localparams, types and width helpers for the
// row collector. Optional build macro: DCA_ROW_COLLECTOR_ZERO_PAD_EN.
package dca_row_collector_pkg;

  // Ping-pong pair: one bank fills while the other drains.
  localparam int NUM_BANK = 2;

  // Bank pointer: a single bit is enough for two banks.
  typedef logic [0:0] bank_ptr_t;

  // Width of the row index inside a bank (never below 1 bit).
  function automatic int f_bw_row_index(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to count 0..n valid rows.
  function automatic int f_bw_num_row(input int n);
    return $clog2(n + 1);
  endfunction

  // The other bank of the ping-pong pair.
  function automatic bank_ptr_t f_other(input bank_ptr_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dca_row_collector_if.sv
// dca_row_collector_if: tensor-row input and matrix output handshakes.
// 'slave' is the collector's view; 'master' is the surrounding producer and
// consumer (the upstream row source and the PE array).
interface dca_row_collector_if
  import dca_row_collector_pkg::*;
#(
  parameter int MATRIX_NUM_ROW = 4,
  parameter int BW_TENSOR_ROW  = 128
);
  localparam int BW_NUM_ROW = f_bw_num_row(MATRIX_NUM_ROW);

  logic                                    rowin_valid;
  logic                                    rowin_last;
  logic [BW_TENSOR_ROW-1:0]                rowin_data;
  logic                                    rowin_ready;

  logic                                    matout_valid;
  logic [MATRIX_NUM_ROW*BW_TENSOR_ROW-1:0] matout_data;
  logic [BW_NUM_ROW-1:0]                   matout_num_row;
  logic                                    matout_last;
  logic                                    matout_ready;

  modport master (
    output rowin_valid, rowin_last, rowin_data, matout_ready,
    input  rowin_ready, matout_valid, matout_data, matout_num_row, matout_last
  );

  modport slave (
    input  rowin_valid, rowin_last, rowin_data, matout_ready,
    output rowin_ready, matout_valid, matout_data, matout_num_row, matout_last
  );

endinterface

// File: rtl/dca_row_collector_bank.sv
// dca_row_collector_bank: one matrix bank. Holds the row storage plus the
// closed flag, row count and last flag of the matrix it carries.
// With DCA_ROW_COLLECTOR_ZERO_PAD_EN defined the storage is zeroed on reset,
// clear and free, so rows past num_row of a partial matrix read as 0.
module dca_row_collector_bank
  import dca_row_collector_pkg::*;
#(
  parameter  int MATRIX_NUM_ROW = 4,
  parameter  int BW_TENSOR_ROW  = 128,
  localparam int BW_ROW_INDEX   = f_bw_row_index(MATRIX_NUM_ROW),
  localparam int BW_NUM_ROW     = f_bw_num_row(MATRIX_NUM_ROW)
)(
  input  logic                                         clk,
  input  logic                                         rstnn,
  input  logic                                         i_clear,
  input  logic                                         i_wr_en,
  input  logic [BW_ROW_INDEX-1:0]                      i_wr_idx,
  input  logic [BW_TENSOR_ROW-1:0]                     i_wr_data,
  input  logic                                         i_close,
  input  logic [BW_NUM_ROW-1:0]                        i_close_num_row,
  input  logic                                         i_close_last,
  input  logic                                         i_free,
  output logic                                         o_closed,
  output logic [BW_NUM_ROW-1:0]                        o_num_row,
  output logic                                         o_last,
  output logic [MATRIX_NUM_ROW-1:0][BW_TENSOR_ROW-1:0] o_rows
);

  logic                                         r_closed;
  logic [BW_NUM_ROW-1:0]                        r_num_row;
  logic                                         r_last;
  logic [MATRIX_NUM_ROW-1:0][BW_TENSOR_ROW-1:0] r_rows;

  // Bank status: close latches count/last, free returns the bank to filling.
  // Close and free never hit the same bank in one cycle (fill bank is open,
  // drain bank is closed), so their order here does not matter.
  always_ff @(posedge clk) begin
    if (!rstnn || i_clear) begin
      r_closed  <= 1'b0;
      r_num_row <= '0;
      r_last    <= 1'b0;
    end else if (i_close) begin
      r_closed  <= 1'b1;
      r_num_row <= i_close_num_row;
      r_last    <= i_close_last;
    end else if (i_free) begin
      r_closed  <= 1'b0;
      r_num_row <= '0;
      r_last    <= 1'b0;
    end
  end

`ifdef DCA_ROW_COLLECTOR_ZERO_PAD_EN
  // Row storage, wiped whenever the bank is emptied so a later partial
  // matrix carries zero padding above its last written row.
  always_ff @(posedge clk) begin
    if (!rstnn || i_clear) begin
      r_rows <= '0;
    end else if (i_free) begin
      r_rows <= '0;
    end else if (i_wr_en) begin
      r_rows[i_wr_idx] <= i_wr_data;
    end
  end
`else
  // Row storage without reset; unused rows keep stale data and consumers
  // rely on the row count.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_rows[i_wr_idx] <= i_wr_data;
    end
  end
`endif

  assign o_closed  = r_closed;
  assign o_num_row = r_num_row;
  assign o_last    = r_last;
  assign o_rows    = r_rows;

endmodule

// File: rtl/dca_row_collector.sv
// dca_row_collector: gathers tensor rows into MATRIX_NUM_ROW-row matrices in
// two ping-pong banks. A bank closes when full or on an accepted last row and
// is presented downstream until the PE array takes it.
// Optional build macro: DCA_ROW_COLLECTOR_ZERO_PAD_EN (zero-pad partial
// matrices and reset the output data to 0).
module dca_row_collector
  import dca_row_collector_pkg::*;
#(
  parameter int MATRIX_NUM_ROW = 4,
  parameter int BW_TENSOR_ROW  = 128
)(
  input logic                clk,
  input logic                rstnn,
  input logic                clear,
  dca_row_collector_if.slave bus
);

  localparam int BW_ROW_INDEX = f_bw_row_index(MATRIX_NUM_ROW);
  localparam int BW_NUM_ROW   = f_bw_num_row(MATRIX_NUM_ROW);

  logic [BW_ROW_INDEX-1:0] r_wcnt;
  bank_ptr_t               r_fill_ptr;
  bank_ptr_t               r_drain_ptr;

  logic                    w_accept;
  logic                    w_wcnt_end;
  logic                    w_close_any;
  logic                    w_free_any;
  logic [BW_NUM_ROW-1:0]   w_close_num_row;

  logic [NUM_BANK-1:0]                                       w_closed;
  logic [NUM_BANK-1:0]                                       w_last;
  logic [NUM_BANK-1:0][BW_NUM_ROW-1:0]                       w_num_row;
  logic [NUM_BANK-1:0][MATRIX_NUM_ROW-1:0][BW_TENSOR_ROW-1:0] w_rows;

  // Ready and valid come straight from the bank closed flags, so there is no
  // combinational path from matout_ready to rowin_ready.
  assign bus.rowin_ready    = ~w_closed[r_fill_ptr];
  assign bus.matout_valid   = w_closed[r_drain_ptr];
  assign bus.matout_num_row = w_num_row[r_drain_ptr];
  assign bus.matout_last    = w_last[r_drain_ptr];
  assign bus.matout_data    = w_rows[r_drain_ptr];

  assign w_accept        = bus.rowin_valid && bus.rowin_ready;
  assign w_wcnt_end      = (r_wcnt == BW_ROW_INDEX'(MATRIX_NUM_ROW - 1));
  // rowin_last without a handshake is ignored: nothing closes on it.
  assign w_close_any     = w_accept && (w_wcnt_end || bus.rowin_last);
  assign w_free_any      = bus.matout_valid && bus.matout_ready;
  assign w_close_num_row = BW_NUM_ROW'(r_wcnt) + BW_NUM_ROW'(1);

  // Write counter and ping-pong pointers; close and free may coincide and
  // both take effect since they always address different banks.
  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      r_wcnt      <= '0;
      r_fill_ptr  <= '0;
      r_drain_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_wcnt <= w_close_any ? '0 : r_wcnt + BW_ROW_INDEX'(1);
      end
      if (w_close_any) begin
        r_fill_ptr <= f_other(r_fill_ptr);
      end
      if (w_free_any) begin
        r_drain_ptr <= f_other(r_drain_ptr);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    localparam bank_ptr_t ID = bank_ptr_t'(b);

    logic w_is_fill;
    logic w_is_drain;

    assign w_is_fill  = (r_fill_ptr == ID);
    assign w_is_drain = (r_drain_ptr == ID);

    dca_row_collector_bank #(
      .MATRIX_NUM_ROW (MATRIX_NUM_ROW),
      .BW_TENSOR_ROW  (BW_TENSOR_ROW)
    ) u_bank (
      .clk             (clk),
      .rstnn           (rstnn),
      .i_clear         (clear),
      .i_wr_en         (w_accept && w_is_fill),
      .i_wr_idx        (r_wcnt),
      .i_wr_data       (bus.rowin_data),
      .i_close         (w_close_any && w_is_fill),
      .i_close_num_row (w_close_num_row),
      .i_close_last    (bus.rowin_last),
      .i_free          (w_free_any && w_is_drain),
      .o_closed        (w_closed[b]),
      .o_num_row       (w_num_row[b]),
      .o_last          (w_last[b]),
      .o_rows          (w_rows[b])
    );
  end

endmodule

// File: doc/dca_row_collector.md
DCA_ROW_COLLECTOR -- requirements
Module: dca_row_collector

Interface
REQ-001 SHALL have parameter MATRIX_NUM_ROW, default 4, meaning rows per assembled matrix (2..16).
REQ-002 SHALL have parameter BW_TENSOR_ROW, default 128, meaning bits per tensor row.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstnn, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port clear, input, 1, synchronous soft clear with the same effect as reset.
REQ-006 SHALL have port rowin_valid, input, 1, upstream tensor-row valid.
REQ-007 SHALL have port rowin_last, input, 1, last row of the current tensor.
REQ-008 SHALL have port rowin_data, input, BW_TENSOR_ROW, tensor row payload.
REQ-009 SHALL have port rowin_ready, output, 1, collector accepts a row.
REQ-010 SHALL have port matout_valid, output, 1, assembled matrix available.
REQ-011 SHALL have port matout_data, output, MATRIX_NUM_ROW*BW_TENSOR_ROW, matrix with row 0 in the LSBs.
REQ-012 SHALL have port matout_num_row, output, clog2(MATRIX_NUM_ROW+1), count of valid rows.
REQ-013 SHALL have port matout_last, output, 1, matrix closed by rowin_last.
REQ-014 SHALL have port matout_ready, input, 1, downstream (PE array) accepts the matrix.

Function
REQ-015 SHALL hold two matrix banks used ping-pong: fill bank (write) and drain bank (read).
REQ-016 SHALL accept a row when rowin_valid and rowin_ready are both high, writing it to the fill bank at row index wcnt and incrementing wcnt.
REQ-017 SHALL close the fill bank when wcnt reaches MATRIX_NUM_ROW or an accepted row carries rowin_last, storing num_row and the last flag, resetting wcnt to 0 and toggling the fill pointer.
REQ-018 SHALL drive rowin_ready high only when the fill bank is not closed; this is a registered state with no combinational path from matout_ready.
REQ-019 SHALL drive matout_valid high while the drain bank is closed; data, num_row and last stay stable while valid is high and ready is low.
REQ-020 SHALL free the drain bank and toggle the drain pointer on a matout_valid and matout_ready handshake.
REQ-021 SHALL emit the first matrix with valid high one cycle after the closing row handshake; latency is 1 cycle.
REQ-022 SHALL handle a close and a free in the same cycle on different banks with both taking effect; the freed bank becomes writable on the next cycle.
REQ-023 SHALL deassert rowin_ready until a bank frees when both banks are closed (full).
REQ-024 SHALL not close a bank and SHALL emit nothing when rowin_last arrives with wcnt==0 with no row accepted; rowin_last is only meaningful with a handshake.
REQ-025 SHALL drop a partially filled bank when clear is asserted mid-fill, discarding all banks.

Reset
REQ-026 SHALL drive on rstnn low or clear high at a clock edge: rowin_ready=1, matout_valid=0, matout_num_row=0, matout_last=0, wcnt=0, both pointers=0, and both banks not closed.
REQ-027 SHALL reset matout_data to 0 when DCA_ROW_COLLECTOR_ZERO_PAD_EN is defined; otherwise matout_data is don't-care.

Configuration
REQ-028 SHALL zero rows num_row..MATRIX_NUM_ROW-1 of a closed partial bank in matout_data when macro DCA_ROW_COLLECTOR_ZERO_PAD_EN is defined, by clearing the bank on free.
REQ-029 SHALL leave unused rows holding stale data when DCA_ROW_COLLECTOR_ZERO_PAD_EN is undefined; consumers then rely on matout_num_row, and no bank-clear logic is built.

Structure
REQ-030 SHALL place the localparams (BW_ROW_INDEX, BW_NUM_ROW, bank count 2) in shared include dca_row_collector_lpara.vb alongside the existing dca_tensor_dim_lpara.vb.
REQ-031 SHALL instantiate one sub-module, dca_row_collector_bank, per bank, holding the row storage, closed flag, num_row and last, with a write port and a free/clear input.

Verification
REQ-032 SHALL test a full fill: N=4, rows 0x1..0x4 with no last, matout_ready=1 -> one cycle after row 4, valid=1, num_row=4, last=0, data={4,3,2,1}.
REQ-033 SHALL test a partial last: rows 0xA,0xB with last on 0xB -> num_row=2, last=1, rows 2..3 equal 0 with the macro defined and are unchecked without it.
REQ-034 SHALL test backpressure: matout_ready=0 with 9 rows streamed -> 8 accepted, rowin_ready=0 after the 8th, output stable; ready=1 -> matrices {1-4},{5-8} in order, then row 9 accepted.
REQ-035 SHALL test simultaneous close and free: 4th row of bank1 in the same cycle as bank0 handshake -> both succeed, no row lost, bank1 valid next cycle.
REQ-036 SHALL test mid-operation reset: rstnn=0 for 1 cycle after 2 of 4 rows -> all outputs at reset values; the next 4 rows form a clean matrix with num_row=4.
REQ-037 SHALL test clear with both banks full: clear=1 -> matout_valid=0 and rowin_ready=1 on the next cycle.
